sram_ctrl: RTL and testbench

Slave-side bridge between the memory self-test driver (single-cycle `write`/`read` strobes, 16-bit `writedata`, registered compare against `readdata`) and an external asynchronous 16-bit SRAM. It converts each accepted strobe into a fixed-length SRAM access with programmable wait states and returns read data with a one-cycle valid pulse. It sits directly downstream of the test driver, on the board-facing side of the design.

---
 rtl/sram_ctrl_pkg.sv | 57 +++++
 rtl/sram_ctrl.sv | 112 +++++++++++
 tb/tb_sram_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the asynchronous SRAM bridge: FSM states,
// wait counter width and the idle/reset levels of the SRAM pins.
package sram_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        RD_ACCESS,
        RD_DONE
    } state_t;

    localparam int WAIT_CNT_W = 4;

    typedef struct packed {
        logic ce_n;
        logic oe_n;
        logic we_n;
        logic ub_n;
        logic lb_n;
        logic dq_oe;
    } pins_t;

    localparam pins_t PINS_RESET = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1,
                                     ub_n: 1'b1, lb_n: 1'b1, dq_oe: 1'b0};

    // Pin levels owned by each state; the bus is never driven while oe_n is low.
    function automatic pins_t pins_for(state_t s);
        pins_t p;
        p = PINS_RESET;
        case (s)
            WR_SETUP, WR_HOLD: begin
                p.ce_n  = 1'b0;
                p.ub_n  = 1'b0;
                p.lb_n  = 1'b0;
                p.dq_oe = 1'b1;
            end
            WR_PULSE: begin
                p.ce_n  = 1'b0;
                p.ub_n  = 1'b0;
                p.lb_n  = 1'b0;
                p.dq_oe = 1'b1;
                p.we_n  = 1'b0;
            end
            RD_ACCESS: begin
                p.ce_n = 1'b0;
                p.oe_n = 1'b0;
                p.ub_n = 1'b0;
                p.lb_n = 1'b0;
            end
            default: ;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Strobe-to-SRAM bridge: turns single-cycle write/read strobes into fixed-length
// asynchronous SRAM cycles with WAIT_CYC wait states and a read-valid pulse.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 20,
    parameter int DATA_W   = 16,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write,
    input  logic              read,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              readdatavalid,
    output logic              waitrequest,
    output logic              cmd_dropped,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_i,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n
);

    localparam logic [WAIT_CNT_W-1:0] WR_LAST = WAIT_CNT_W'(WAIT_CYC - 1);
    localparam logic [WAIT_CNT_W-1:0] RD_LAST = WAIT_CNT_W'(WAIT_CYC);

    state_t                state, state_next;
    logic [WAIT_CNT_W-1:0] wait_cnt, cnt_next;
    logic                  accept_wr, accept_rd, capture, drop;
    pins_t                 pins;

    assign waitrequest = (state != IDLE);

    always_comb begin
        state_next = state;
        cnt_next   = wait_cnt;
        accept_wr  = 1'b0;
        accept_rd  = 1'b0;
        capture    = 1'b0;
        drop       = (state != IDLE) && (write || read);
        case (state)
            IDLE: begin
                if (write) begin
                    accept_wr  = 1'b1;
                    drop       = read;
                    state_next = WR_SETUP;
                end else if (read) begin
                    accept_rd  = 1'b1;
                    cnt_next   = '0;
                    state_next = RD_ACCESS;
                end
            end
            WR_SETUP: begin
                cnt_next   = '0;
                state_next = WR_PULSE;
            end
            WR_PULSE: begin
                if (wait_cnt == WR_LAST) state_next = WR_HOLD;
                else                     cnt_next   = wait_cnt + 1'b1;
            end
            WR_HOLD: state_next = IDLE;
            RD_ACCESS: begin
                if (wait_cnt == RD_LAST) begin
                    capture    = 1'b1;
                    state_next = RD_DONE;
                end else begin
                    cnt_next = wait_cnt + 1'b1;
                end
            end
            RD_DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Pins are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            pins          <= PINS_RESET;
            sram_addr     <= '0;
            sram_dq_o     <= '0;
            readdata      <= '0;
            readdatavalid <= 1'b0;
            cmd_dropped   <= 1'b0;
        end else begin
            state         <= state_next;
            wait_cnt      <= cnt_next;
            pins          <= pins_for(state_next);
            readdatavalid <= capture;
            if (accept_wr || accept_rd) sram_addr <= address;
            if (accept_wr)              sram_dq_o <= writedata;
            if (capture)                readdata  <= sram_dq_i;
            if (drop)                   cmd_dropped <= 1'b1;
        end
    end

    assign sram_ce_n  = pins.ce_n;
    assign sram_oe_n  = pins.oe_n;
    assign sram_we_n  = pins.we_n;
    assign sram_ub_n  = pins.ub_n;
    assign sram_lb_n  = pins.lb_n;
    assign sram_dq_oe = pins.dq_oe;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: a default-parameter instance checked cycle by cycle against
// a timing model, plus a WAIT_CYC=1 / 16-word instance for a write/read sweep.
module tb_sram_ctrl;

    localparam int W = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- main instance (defaults) ----------------
    logic        write = 0, read = 0;
    logic [19:0] address = '0;
    logic [15:0] writedata = '0;
    logic [15:0] readdata, dq_o, dq_i;
    logic [19:0] sram_addr;
    logic        readdatavalid, waitrequest, cmd_dropped, dq_oe;
    logic        ce_n, oe_n, we_n, ub_n, lb_n;

    sram_ctrl dut (
        .clk(clk), .rst(rst), .write(write), .read(read), .address(address),
        .writedata(writedata), .readdata(readdata), .readdatavalid(readdatavalid),
        .waitrequest(waitrequest), .cmd_dropped(cmd_dropped), .sram_addr(sram_addr),
        .sram_dq_o(dq_o), .sram_dq_oe(dq_oe), .sram_dq_i(dq_i), .sram_ce_n(ce_n),
        .sram_oe_n(oe_n), .sram_we_n(we_n), .sram_ub_n(ub_n), .sram_lb_n(lb_n)
    );

    // Asynchronous SRAM device, sampled mid-cycle.
    logic [15:0] dev_mem [logic [19:0]];
    initial dq_i = 16'hBEEF;
    always @(negedge clk) begin
        if (!ce_n && !we_n) dev_mem[sram_addr] = dq_o;
        if (!ce_n && !oe_n) dq_i = dev_mem.exists(sram_addr) ? dev_mem[sram_addr] : 16'h0000;
        else                dq_i = 16'hBEEF;
    end

    // Reference: cycle offset from the accepted strobe decides every pin.
    int          cyc = 0;
    int          t_acc = -100;
    bit          kind_wr = 0;
    logic [19:0] m_addr = '0;
    logic [15:0] m_dq = '0, m_rd = '0, m_rdval = '0;
    bit          m_drop = 0;
    logic [15:0] ref_mem [logic [19:0]];

    always @(negedge clk) begin
        int d;
        bit busy, wr, rd, rd_on, rdv;
        d     = cyc - t_acc;
        busy  = (d >= 1) && (d <= W + 2);
        wr    = busy && kind_wr;
        rd    = busy && !kind_wr;
        rd_on = rd && (d <= W + 1);
        rdv   = rd && (d == W + 2);
        if (rdv) m_rd = m_rdval;
        check_val("waitrequest", waitrequest, busy);
        check_val("ce_n", ce_n, !(wr || rd_on));
        check_val("ub_n", ub_n, !(wr || rd_on));
        check_val("lb_n", lb_n, !(wr || rd_on));
        check_val("oe_n", oe_n, !rd_on);
        check_val("we_n", we_n, !(wr && d >= 2 && d <= W + 1));
        check_val("dq_oe", dq_oe, wr);
        check_val("readdatavalid", readdatavalid, rdv);
        check_val("readdata", readdata, m_rd);
        check_val("sram_addr", sram_addr, m_addr);
        check_val("dq_o", dq_o, m_dq);
        check_val("cmd_dropped", cmd_dropped, m_drop);
        check_val("contention_oe", dq_oe && !oe_n, 1'b0);
        check_val("contention_ce", dq_oe && ce_n, 1'b0);
        if (rst) begin
            t_acc  = -100;
            m_addr = '0;
            m_dq   = '0;
            m_rd   = '0;
            m_drop = 0;
        end else if (write || read) begin
            if (busy) begin
                m_drop = 1;
            end else begin
                t_acc   = cyc;
                kind_wr = write;
                m_addr  = address;
                if (write) begin
                    m_dq = writedata;
                    ref_mem[address] = writedata;
                    if (read) m_drop = 1;
                end else begin
                    m_rdval = ref_mem.exists(address) ? ref_mem[address] : 16'h0000;
                end
            end
        end
        cyc++;
    end

    // ---------------- sweep instance (WAIT_CYC=1, 16 words) ----------------
    logic       s_write = 0, s_read = 0;
    logic [3:0] s_address = '0, s_addr;
    logic [15:0] s_writedata = '0, s_readdata, s_dq_o, s_dq_i;
    logic       s_rdv, s_wait, s_drop, s_dq_oe, s_ce_n, s_oe_n, s_we_n, s_ub_n, s_lb_n;

    sram_ctrl #(.ADDR_W(4), .DATA_W(16), .WAIT_CYC(1)) dut_s (
        .clk(clk), .rst(rst), .write(s_write), .read(s_read), .address(s_address),
        .writedata(s_writedata), .readdata(s_readdata), .readdatavalid(s_rdv),
        .waitrequest(s_wait), .cmd_dropped(s_drop), .sram_addr(s_addr),
        .sram_dq_o(s_dq_o), .sram_dq_oe(s_dq_oe), .sram_dq_i(s_dq_i), .sram_ce_n(s_ce_n),
        .sram_oe_n(s_oe_n), .sram_we_n(s_we_n), .sram_ub_n(s_ub_n), .sram_lb_n(s_lb_n)
    );

    logic [15:0] s_mem [16];
    int          s_rdv_cnt = 0;
    bit          sweep_on = 0;
    initial begin
        for (int i = 0; i < 16; i++) s_mem[i] = 16'h0000;
        s_dq_i = 16'hBEEF;
    end
    always @(negedge clk) begin
        if (!s_ce_n && !s_we_n) s_mem[s_addr] = s_dq_o;
        s_dq_i = (!s_ce_n && !s_oe_n) ? s_mem[s_addr] : 16'hBEEF;
        if (sweep_on) begin
            check_val("sweep_contention_oe", s_dq_oe && !s_oe_n, 1'b0);
            check_val("sweep_contention_ce", s_dq_oe && s_ce_n, 1'b0);
            if (s_rdv) begin
                s_rdv_cnt++;
                check_val("sweep_readdata", s_readdata, 16'h5555);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input bit w, input bit r, input logic [19:0] a, input logic [15:0] dat);
        write = w; read = r; address = a; writedata = dat;
        tick();
        write = 0; read = 0;
    endtask

    task automatic s_access(input bit w, input logic [3:0] a, input logic [15:0] dat);
        check_val("sweep_idle", s_wait, 1'b0);
        s_write = w; s_read = !w; s_address = a; s_writedata = dat;
        tick();
        s_write = 0; s_read = 0;
        tick(3);
    endtask

    logic [19:0] pool [8];

    initial begin
        tick(3);
        rst = 0;
        tick(2);
        // write then read timing, simultaneous strobes
        strobe(1, 0, 20'h00012, 16'h5555); tick(5);
        strobe(1, 0, 20'h00012, 16'hA5A5); tick(5);
        strobe(0, 1, 20'h00012, 16'h0000); tick(6);
        strobe(1, 1, 20'h00034, 16'h1234); tick(5);
        strobe(0, 1, 20'h00034, 16'h0000); tick(6);
        rst = 1; tick(); rst = 0; tick(2);
        // read strobe at N+2 during a write, next strobe at N+5
        strobe(1, 0, 20'h00056, 16'h9999); tick();
        strobe(0, 1, 20'h00056, 16'h0000); tick(2);
        strobe(0, 1, 20'h00056, 16'h0000); tick(6);
        // reset during WR_PULSE; this address is never read back
        rst = 1; tick(); rst = 0;
        strobe(1, 0, 20'h0ABCD, 16'h0F0F); tick();
        rst = 1; tick(); rst = 0; tick(3);
        // randomized strobes, including ones that land while busy
        for (int i = 0; i < 8; i++) pool[i] = 20'($urandom_range(0, 20'hFFFFF)) & 20'hF0FFF;
        for (int i = 0; i < 600; i++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            write     = (sel < 2) || (sel == 9);
            read      = (sel >= 2 && sel < 4) || (sel == 9);
            address   = pool[$urandom_range(0, 7)];
            writedata = 16'($urandom);
            tick();
        end
        write = 0; read = 0;
        tick(6);
        // sweep on the WAIT_CYC=1 instance
        rst = 1; tick(); rst = 0; tick();
        sweep_on = 1;
        for (int a = 0; a < 16; a++) s_access(1, 4'(a), 16'h5555);
        for (int a = 0; a < 16; a++) s_access(0, 4'(a), 16'h0000);
        tick(2);
        check_val("sweep_rdv_count", s_rdv_cnt, 16);
        check_val("sweep_dropped", s_drop, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
